// File: rtl/hazard_fwd_unit.sv
// hazard_fwd_unit: EX/MEM/WB destination-tag tracking, ALU operand forwarding
// selects, load-use stall, branch flush and a saturating stall counter.

// Per-operand forwarding select. {c1,c0}: 01 = MEM result, 10 = WB data,
// 00 = register file. 11 never occurs because c1 is masked by a MEM hit.
module hfu_fwd_sel #(
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] src,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic                  mem_rw,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic                  wb_rw,
  input  logic                  en,
  output logic                  c0,
  output logic                  c1
);
  logic mem_hit, wb_hit;

  // Hit detection; $0 is never a forwarding source, MEM beats WB
  always_comb begin
    mem_hit = mem_rw && (mem_rd != '0) && (mem_rd == src);
    wb_hit  = wb_rw  && (wb_rd  != '0) && (wb_rd  == src);
    c0      = en && mem_hit;
    c1      = en && !mem_hit && wb_hit;
  end
endmodule

module hazard_fwd_unit #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_rs_used,
  input  logic                  id_rt_used,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  ex_branch_taken,
  output logic                  fwd_a_c0,
  output logic                  fwd_a_c1,
  output logic                  fwd_b_c0,
  output logic                  fwd_b_c1,
  output logic                  stall,
  output logic                  flush_id,
  output logic [CNT_W-1:0]      stall_cnt
);
  localparam int NUM_OPS = 2;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rs;
    logic [REG_ADDR_W-1:0] rt;
    logic [REG_ADDR_W-1:0] rd;
    logic                  reg_write;
    logic                  mem_read;
  } ex_tag_t;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic                  reg_write;
  } wr_tag_t;

  ex_tag_t ex_q, ex_d;
  wr_tag_t mem_q, wb_q;
  logic    load_use;

  // Next EX tag: a bubble (all zero) replaces the ID instruction on stall/flush
  always_comb begin
    ex_d = '0;
    if (!(stall || ex_branch_taken)) begin
      ex_d.rs        = id_rs;
      ex_d.rt        = id_rt;
      ex_d.rd        = id_rd;
      ex_d.reg_write = id_reg_write;
      ex_d.mem_read  = id_mem_read;
    end
  end

  // Tag pipeline: MEM and WB advance unconditionally
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= '{rd: ex_q.rd, reg_write: ex_q.reg_write};
      wb_q  <= mem_q;
    end
  end

  // Load in EX whose result the ID instruction really reads; flush overrides
  always_comb begin
    load_use = ex_q.mem_read && ex_q.reg_write && (ex_q.rd != '0) &&
               ((id_rs_used && (id_rs == ex_q.rd)) ||
                (id_rt_used && (id_rt == ex_q.rd)));
    stall    = load_use && !ex_branch_taken && !rst;
    flush_id = ex_branch_taken && !rst;
  end

  // Stall performance counter, sticks at all-ones
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          stall_cnt <= '0;
    else if (stall && ~&stall_cnt)    stall_cnt <= stall_cnt + CNT_W'(1);
  end

  logic [NUM_OPS-1:0][REG_ADDR_W-1:0] op_src;
  logic [NUM_OPS-1:0]                 sel_c0, sel_c1;

  assign op_src[0] = ex_q.rs;
  assign op_src[1] = ex_q.rt;

  for (genvar g = 0; g < NUM_OPS; g++) begin : g_op
    hfu_fwd_sel #(.REG_ADDR_W(REG_ADDR_W)) u_sel (
      .src    (op_src[g]),
      .mem_rd (mem_q.rd),
      .mem_rw (mem_q.reg_write),
      .wb_rd  (wb_q.rd),
      .wb_rw  (wb_q.reg_write),
      .en     (!rst),
      .c0     (sel_c0[g]),
      .c1     (sel_c1[g])
    );
  end

  assign fwd_a_c0 = sel_c0[0];
  assign fwd_a_c1 = sel_c1[0];
  assign fwd_b_c0 = sel_c0[1];
  assign fwd_b_c1 = sel_c1[1];
endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Bench for hazard_fwd_unit: directed cycle table, reset/saturation sequences,
// then random traffic against a pipeline-history reference model.
module tb_hazard_fwd_unit;
  localparam int AW    = 5;
  localparam int CNT_W = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] id_rs, id_rt, id_rd;
  logic          id_rs_used, id_rt_used, id_reg_write, id_mem_read, ex_branch_taken;
  logic          fwd_a_c0, fwd_a_c1, fwd_b_c0, fwd_b_c1, stall, flush_id;
  logic [CNT_W-1:0] stall_cnt;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  hazard_fwd_unit #(.REG_ADDR_W(AW), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt), .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
    .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .ex_branch_taken(ex_branch_taken),
    .fwd_a_c0(fwd_a_c0), .fwd_a_c1(fwd_a_c1), .fwd_b_c0(fwd_b_c0), .fwd_b_c1(fwd_b_c1),
    .stall(stall), .flush_id(flush_id), .stall_cnt(stall_cnt)
  );

  typedef struct {
    logic [AW-1:0] rs, rt, rd;
    logic rsu, rtu, rw, mr, br;
    int fa, fb, st, fl, cnt;
  } vec_t;

  typedef struct {
    logic [AW-1:0] rs, rt, rd;
    logic rw, mr;
  } ins_t;

  function automatic vec_t mk(int rs, int rsu, int rt, int rtu, int rd, int rw, int mr,
                              int br, int fa, int fb, int st, int fl, int cnt);
    vec_t v;
    v.rs = AW'(rs); v.rsu = rsu[0]; v.rt = AW'(rt); v.rtu = rtu[0];
    v.rd = AW'(rd); v.rw = rw[0]; v.mr = mr[0]; v.br = br[0];
    v.fa = fa; v.fb = fb; v.st = st; v.fl = fl; v.cnt = cnt;
    return v;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  task automatic put(input vec_t v);
    id_rs = v.rs; id_rs_used = v.rsu; id_rt = v.rt; id_rt_used = v.rtu;
    id_rd = v.rd; id_reg_write = v.rw; id_mem_read = v.mr; ex_branch_taken = v.br;
  endtask

  task automatic chk_out(input string tag, input int fa, input int fb, input int st,
                         input int fl, input int cnt);
    chk({tag, ".fwd_a"}, int'({fwd_a_c1, fwd_a_c0}), fa);
    chk({tag, ".fwd_b"}, int'({fwd_b_c1, fwd_b_c0}), fb);
    chk({tag, ".stall"}, int'(stall), st);
    chk({tag, ".flush"}, int'(flush_id), fl);
    chk({tag, ".cnt"},   int'(stall_cnt), cnt);
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  // Reference model: the last three issued instructions, by pipeline position
  ins_t m_ex, m_mem, m_wb;

  function automatic int ref_sel(logic [AW-1:0] s, ins_t m, ins_t w);
    if (m.rw && m.rd != 0 && m.rd == s) return 1;
    if (w.rw && w.rd != 0 && w.rd == s) return 2;
    return 0;
  endfunction

  vec_t tbl[16];

  initial begin
    vec_t nop, v;
    ins_t bub;
    int exp_cnt, fa, fb, st;
    bit haz;
    bub = '{rs: 0, rt: 0, rd: 0, rw: 0, mr: 0};
    nop = mk(0,0,0,0,0,0,0,0, 0,0,0,0,0);

    // Directed program; one row per cycle, expectations at mid-cycle
    tbl[0]  = mk(1,1,2,1, 3,1,0,0, 0,0,0,0,0);  // I1 writes r3
    tbl[1]  = mk(3,1,4,1, 6,1,0,0, 0,0,0,0,0);  // I2 reads r3
    tbl[2]  = mk(0,0,0,0, 5,1,0,0, 1,0,0,0,0);  // I2 in EX: A from MEM
    tbl[3]  = mk(0,0,0,0, 5,1,0,0, 0,0,0,0,0);
    tbl[4]  = mk(0,0,0,0, 5,1,0,0, 0,0,0,0,0);  // third write of r5
    tbl[5]  = mk(0,0,5,1, 8,1,0,0, 0,0,0,0,0);  // reader rt=r5
    tbl[6]  = mk(1,1,0,0, 7,1,1,0, 0,1,0,0,0);  // reader in EX: B=01 not 10; load r7 in ID
    tbl[7]  = mk(7,1,2,1, 9,1,0,0, 0,0,1,0,0);  // load-use stall
    tbl[8]  = mk(7,1,2,1, 9,1,0,0, 0,0,0,0,1);  // held ID, bubble in EX
    tbl[9]  = mk(0,0,0,0, 0,1,0,0, 2,0,0,0,1);  // consumer in EX: A from WB; rd=0 writer
    tbl[10] = mk(0,1,0,1,10,1,0,0, 0,0,0,0,1);  // reader of $0
    tbl[11] = mk(0,0,0,0, 7,1,1,0, 0,0,0,0,1);  // $0 not forwarded; load r7
    tbl[12] = mk(7,0,0,0,11,1,0,0, 0,0,0,0,1);  // rs=r7 unused: no stall
    tbl[13] = mk(0,0,0,0, 4,1,1,0, 1,0,0,0,1);  // load r4
    tbl[14] = mk(4,1,0,0,12,1,0,1, 0,0,0,1,1);  // load-use + branch: flush wins
    tbl[15] = mk(0,0,0,0, 0,0,0,0, 0,0,0,0,1);  // bubble in EX, no forward from r4 reader

    // Reset state
    rst = 1'b1; put(nop);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_out("reset", 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 16; i++) begin
      put(tbl[i]);
      @(negedge clk);
      chk_out($sformatf("tbl%0d", i), tbl[i].fa, tbl[i].fb, tbl[i].st, tbl[i].fl, tbl[i].cnt);
      next_cycle();
    end

    // Repeated load-use stalls: counter climbs 1->2->3 then holds
    for (int k = 0; k < 3; k++) begin
      put(mk(0,0,0,0,7,1,1,0, 0,0,0,0,0));
      next_cycle();
      put(mk(7,1,0,0,9,1,0,0, 0,0,0,0,0));
      @(negedge clk);
      chk($sformatf("sat%0d.stall", k), int'(stall), 1);
      next_cycle();
      put(nop);
      @(negedge clk);
      chk($sformatf("sat%0d.cnt", k), int'(stall_cnt), (k + 2 > 3) ? 3 : k + 2);
      next_cycle();
    end

    // Async reset in the middle of a load-use stall, with a branch pending
    put(mk(0,0,0,0,7,1,1,0, 0,0,0,0,0));
    next_cycle();
    put(mk(7,1,0,0,9,1,0,0, 0,0,0,0,0));
    @(negedge clk);
    chk("pre_rst.stall", int'(stall), 1);
    #1 rst = 1'b1; ex_branch_taken = 1'b1;
    #1 chk_out("mid_rst", 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    rst = 1'b0; put(nop);
    m_ex = bub; m_mem = bub; m_wb = bub; exp_cnt = 0;

    // Random traffic against the reference model
    for (int c = 0; c < 500; c++) begin
      v = mk($urandom_range(0,3), $urandom_range(0,1), $urandom_range(0,3), $urandom_range(0,1),
             $urandom_range(0,3), $urandom_range(0,1), $urandom_range(0,1),
             ($urandom_range(0,9) == 0) ? 1 : 0, 0,0,0,0,0);
      put(v);
      fa  = ref_sel(m_ex.rs, m_mem, m_wb);
      fb  = ref_sel(m_ex.rt, m_mem, m_wb);
      haz = m_ex.mr && m_ex.rw && m_ex.rd != 0 &&
            ((v.rsu && v.rs == m_ex.rd) || (v.rtu && v.rt == m_ex.rd));
      st  = (haz && !v.br) ? 1 : 0;
      @(negedge clk);
      chk_out($sformatf("rnd%0d", c), fa, fb, st, int'(v.br), exp_cnt);
      next_cycle();
      if (st == 1 && exp_cnt < 3) exp_cnt++;
      m_wb  = m_mem;
      m_mem = m_ex;
      if (st == 1 || v.br) m_ex = bub;
      else m_ex = '{rs: v.rs, rt: v.rt, rd: v.rd, rw: v.rw, mr: v.mr};
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
